// File: rtl/updown_step_arbiter_if.sv
// rtl/updown_step_arbiter_if.sv - request/grant/step bundle between requesters and the up/down step arbiter
interface updown_step_arbiter_if #(
    parameter int WIDTH = 2
);
    logic             req_up;
    logic             req_dn;
    logic             clr;
    logic             gnt_up;
    logic             gnt_dn;
    logic             step_en;
    logic             step_up;
    logic             sat;
    logic             busy;
    logic [WIDTH-1:0] count;

    modport master (
        output req_up, req_dn, clr,
        input  gnt_up, gnt_dn, step_en, step_up, sat, busy, count
    );

    modport slave (
        input  req_up, req_dn, clr,
        output gnt_up, gnt_dn, step_en, step_up, sat, busy, count
    );
endinterface

// File: rtl/updown_step_arbiter.sv
// rtl/updown_step_arbiter.sv - round-robin up/down step arbiter owning a saturating count
// Optional feature: define UPDN_WRAP_EN to wrap at the limits instead of saturating.
module updown_step_arbiter #(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  CLOCK_50,
    input  logic [0:0]            KEY,
    updown_step_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    localparam int               TW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [WIDTH-1:0] CMAX = '1;
    localparam logic [TW-1:0]    LAST = TW'(HOLD_CYCLES - 1);

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic             next_up, next_up_n;
    logic             gnt_up_q, gnt_up_n, gnt_dn_q, gnt_dn_n;
    logic             step_en_q, step_en_n, step_up_q, step_up_n;
    logic             sat_q, sat_n, busy_q;
    logic             pick_up;

    always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
        if (!KEY[0]) begin
            state     <= IDLE;
            timer     <= '0;
            count_q   <= '0;
            next_up   <= 1'b1;
            gnt_up_q  <= 1'b0;
            gnt_dn_q  <= 1'b0;
            step_en_q <= 1'b0;
            step_up_q <= 1'b0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            count_q   <= count_n;
            next_up   <= next_up_n;
            gnt_up_q  <= gnt_up_n;
            gnt_dn_q  <= gnt_dn_n;
            step_en_q <= step_en_n;
            step_up_q <= step_up_n;
            sat_q     <= sat_n;
            busy_q    <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        count_n   = count_q;
        next_up_n = next_up;
        gnt_up_n  = 1'b0;
        gnt_dn_n  = 1'b0;
        step_en_n = 1'b0;
        step_up_n = step_up_q;
        sat_n     = 1'b0;
        // With both requests up, next_up decides; a lone request always wins.
        pick_up   = bus.req_up && (!bus.req_dn || next_up);
        if (bus.clr) begin
            state_n = IDLE;
            timer_n = '0;
            count_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_up || bus.req_dn) begin
                        state_n   = GRANT;
                        next_up_n = !pick_up;
                        gnt_up_n  = pick_up;
                        gnt_dn_n  = !pick_up;
`ifdef UPDN_WRAP_EN
                        step_en_n = 1'b1;
                        step_up_n = pick_up;
                        count_n   = pick_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
`else
                        if (pick_up ? (count_q == CMAX) : (count_q == '0)) begin
                            sat_n = 1'b1;
                        end else begin
                            step_en_n = 1'b1;
                            step_up_n = pick_up;
                            count_n   = pick_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
                        end
`endif
                    end
                end
                GRANT: begin
                    timer_n = '0;
                    state_n = (HOLD_CYCLES > 0) ? HOLD : IDLE;
                end
                HOLD: begin
                    if (timer == LAST) begin
                        state_n = IDLE;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.gnt_up  = gnt_up_q;
    assign bus.gnt_dn  = gnt_dn_q;
    assign bus.step_en = step_en_q;
    assign bus.step_up = step_up_q;
    assign bus.sat     = sat_q;
    assign bus.busy    = busy_q;
    assign bus.count   = count_q;
endmodule
